ram_loader: RTL

Boot-time program loader that sits directly upstream of the 16x8 RAM and drives its we/address/data_in write port. It takes a byte stream over a valid/ready handshake (from the UART receiver or a switch panel) and parses a frame of length byte, payload bytes, checksum byte. Payload bytes are written to consecutive RAM addresses. While loading, it holds the CPU off the RAM bus through busy.

---
 rtl/arch_defs_pkg.sv | 18 +
 rtl/ram_loader.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/arch_defs_pkg.sv
// Shared definitions for the boot-time RAM loader and the 16x8 program RAM.
package arch_defs_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int RAM_DEPTH      = 1 << DEF_ADDR_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    GET_LEN,
    GET_DATA,
    WRITE,
    GET_CSUM,
    DONE,
    ERROR
  } loader_state_t;

endpackage

// File: rtl/ram_loader.sv
// Boot-time program loader: parses a length/payload/checksum frame from a
// valid/ready byte stream and writes the payload into consecutive RAM words.
// Every output comes straight from a register.
module ram_loader
  import arch_defs_pkg::*;
#(
  parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [DATA_WIDTH-1:0] byte_in,
  output logic                  byte_ready,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  // Wide enough to hold both the received length byte and the RAM depth, so
  // the length is range-checked without truncation.
  localparam int CNT_W = ((DATA_WIDTH > ADDR_WIDTH) ? DATA_WIDTH : ADDR_WIDTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(1) << ADDR_WIDTH;

  loader_state_t         r_state;
  logic [CNT_W-1:0]      r_len;
  logic [CNT_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_sum;
  logic                  r_byte_ready;
  logic                  r_ram_we;
  logic [ADDR_WIDTH-1:0] r_ram_address;
  logic [DATA_WIDTH-1:0] r_ram_data;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;

  logic                  w_accept;
  logic [CNT_W-1:0]      w_len_ext;
  logic                  w_len_bad;
  logic [CNT_W-1:0]      w_idx_next;
  logic [DATA_WIDTH-1:0] w_sum_next;
  logic [ADDR_WIDTH-1:0] w_wr_addr;

  assign w_accept   = byte_valid & r_byte_ready;
  assign w_len_ext  = CNT_W'(byte_in);
  assign w_len_bad  = (w_len_ext == '0) || (w_len_ext > DEPTH);
  assign w_idx_next = r_idx + CNT_W'(1);
  assign w_sum_next = r_sum + byte_in;
  // Address arithmetic wraps naturally at the RAM size.
  assign w_wr_addr  = BASE_ADDR + r_idx[ADDR_WIDTH-1:0];

  assign byte_ready  = r_byte_ready;
  assign ram_we      = r_ram_we;
  assign ram_address = r_ram_address;
  assign ram_data    = r_ram_data;
  assign busy        = r_busy;
  assign done        = r_done;
  assign error       = r_error;

  // Frame-parsing FSM; outputs are set on the transition into each state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_len         <= '0;
      r_idx         <= '0;
      r_sum         <= '0;
      r_byte_ready  <= 1'b0;
      r_ram_we      <= 1'b0;
      r_ram_address <= '0;
      r_ram_data    <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            r_state      <= GET_LEN;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_byte_ready <= 1'b1;
          end
        end
        GET_LEN: begin
          if (w_accept) begin
            if (w_len_bad) begin
              r_state      <= ERROR;
              r_byte_ready <= 1'b0;
              r_busy       <= 1'b0;
              r_error      <= 1'b1;
            end else begin
              r_len   <= w_len_ext;
              r_idx   <= '0;
              r_sum   <= '0;
              r_state <= GET_DATA;
            end
          end
        end
        GET_DATA: begin
          if (w_accept) begin
            r_ram_data    <= byte_in;
            r_ram_address <= w_wr_addr;
            r_sum         <= w_sum_next;
            r_state       <= WRITE;
            r_byte_ready  <= 1'b0;
            r_ram_we      <= 1'b1;
          end
        end
        WRITE: begin
          // The RAM samples address/data on the edge that leaves this state.
          r_ram_we     <= 1'b0;
          r_byte_ready <= 1'b1;
          r_idx        <= w_idx_next;
          r_state      <= (w_idx_next == r_len) ? GET_CSUM : GET_DATA;
        end
        GET_CSUM: begin
          if (w_accept) begin
            r_byte_ready <= 1'b0;
            r_busy       <= 1'b0;
            if (w_sum_next == '0) begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_error <= 1'b1;
              r_state <= ERROR;
            end
          end
        end
        default: begin
          r_state      <= IDLE;
          r_byte_ready <= 1'b0;
          r_ram_we     <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
